load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 169 ++++++++++++++++
 tb/tb_load_store_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding access, lane steering, load timeout.
// Define LSU_MISALIGN_TRAP_EN to complete misaligned half/word accesses at once with misaligned set.
module load_store_unit #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

    state_t      state;
    logic [1:0]  lo_q;
    logic [1:0]  size_q;
    logic        sx_q;
    logic        st_q;
    logic [15:0] cnt;

    logic [1:0]  lo;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [15:0] lane;
    logic [31:0] ext;

    // lo is the byte offset already aligned down to the access size
    always_comb begin
        lo    = alu_result[1:0];
        strb  = 4'b1111;
        wdata = store_data;
        unique case (1'b1)
            funct3[1]: begin
                lo    = 2'b00;
                strb  = 4'b1111;
                wdata = store_data;
            end
            funct3[1:0] == 2'b01: begin
                lo    = {alu_result[1], 1'b0};
                strb  = 4'b0011 << lo;
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                lo    = alu_result[1:0];
                strb  = 4'b0001 << lo;
                wdata = {4{store_data[7:0]}};
            end
        endcase
    end

    always_comb begin
        lane = 16'(mem_rdata >> {lo_q, 3'b000});
        ext  = mem_rdata;
        unique case (1'b1)
            size_q[1]:        ext = mem_rdata;
            size_q == 2'b01:  ext = {{16{sx_q & lane[15]}}, lane};
            default:          ext = {{24{sx_q & lane[7]}}, lane[7:0]};
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic trap;
    assign trap = funct3[1] ? |alu_result[1:0] : (funct3[0] & alu_result[0]);
`else
    assign misaligned = 1'b0;
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lo_q      <= 2'b00;
            size_q    <= 2'b00;
            sx_q      <= 1'b0;
            st_q      <= 1'b0;
            cnt       <= 16'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wstrb <= 4'b0000;
            mem_wdata <= 32'd0;
            done      <= 1'b0;
            load_data <= 32'd0;
            bus_err   <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misaligned <= 1'b0;
`endif
        end else begin
            done    <= 1'b0;
            bus_err <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misaligned <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (start) begin
                        lo_q   <= lo;
                        size_q <= funct3[1:0];
                        sx_q   <= ~funct3[2];
                        st_q   <= is_store;
`ifdef LSU_MISALIGN_TRAP_EN
                        if (trap) begin
                            state      <= DONE;
                            done       <= 1'b1;
                            misaligned <= 1'b1;
                        end else
`endif
                        begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= {alu_result[31:2], 2'b00};
                            mem_wstrb <= is_store ? strb : 4'b0000;
                            mem_wdata <= is_store ? wdata : 32'd0;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wstrb <= 4'b0000;
                        cnt       <= 16'd0;
                        if (st_q) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt + 16'd1;
                    if (mem_rvalid) begin
                        load_data <= ext;
                        state     <= DONE;
                        done      <= 1'b1;
                    end else if (cnt == TMO_LAST) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        bus_err <= 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed accesses, expected bus and completion queued.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] alu_result = 32'd0;
    logic [31:0] store_data = 32'd0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        busy, done, misaligned, bus_err;
    logic [31:0] load_data;

    load_store_unit #(.TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
        .funct3(funct3), .alu_result(alu_result), .store_data(store_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy),
        .done(done), .load_data(load_data), .misaligned(misaligned),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        int          cyc;
        logic [31:0] ld;
        logic        mis;
        logic        err;
    } dexp_t;

    typedef struct {
        string       nm;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wd;
        logic        chkwd;
    } bexp_t;

    dexp_t       dq[$];
    bexp_t       bq[$];
    int          cyc = 0;
    int          ncmp = 0;
    int          nfail = 0;
    logic [31:0] last_ld = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // monitor: completion and bus handshakes are checked against the queues
    always @(negedge clk) begin : mon
        dexp_t d;
        bexp_t b;
        if (done) begin
            if (dq.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                d = dq.pop_front();
                chk({d.nm, "_cyc"}, cyc, d.cyc);
                chk({d.nm, "_ld"}, load_data, d.ld);
                chk({d.nm, "_mis"}, {31'd0, misaligned}, {31'd0, d.mis});
                chk({d.nm, "_err"}, {31'd0, bus_err}, {31'd0, d.err});
            end
        end
        if (mem_req && bq.size() == 0) begin
            chk("unexpected_req", 32'd1, 32'd0);
        end else if (mem_req && mem_gnt) begin
            b = bq.pop_front();
            chk({b.nm, "_addr"}, mem_addr, b.addr);
            chk({b.nm, "_we"}, {31'd0, mem_we}, {31'd0, b.we});
            chk({b.nm, "_strb"}, {28'd0, mem_wstrb}, {28'd0, b.strb});
            if (b.chkwd) chk({b.nm, "_wdata"}, mem_wdata, b.wd);
        end
    end

    task automatic drive_start(input logic st, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] d,
                               output int t);
        @(posedge clk); #1;
        start = 1'b1; is_store = st; funct3 = f3; alu_result = a; store_data = d;
        t = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic gnt_at(input int g);
        while (cyc < g) begin @(posedge clk); #1; end
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
    endtask

    task automatic rv_at(input int r, input logic [31:0] d);
        while (cyc < r) begin @(posedge clk); #1; end
        mem_rvalid = 1'b1;
        mem_rdata  = d;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (busy && n < 40);
        if (busy) chk({nm, "_idle_timeout"}, {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_load(input string nm, input logic [2:0] f3, input logic [31:0] a,
                           input int gd, input int rd, input logic [31:0] rdata,
                           input logic [31:0] ld, input logic [31:0] ma);
        int t, g;
        drive_start(1'b0, f3, a, 32'h0, t);
        g = t + 1 + gd;
        bq.push_back('{nm, ma, 1'b0, 4'b0000, 32'h0, 1'b0});
        dq.push_back('{nm, g + rd + 1, ld, 1'b0, 1'b0});
        last_ld = ld;
        gnt_at(g);
        rv_at(g + rd, rdata);
        wait_idle(nm);
    endtask

    task automatic do_store(input string nm, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] sd, input int gd, input logic [31:0] ma,
                            input logic [3:0] strb, input logic [31:0] wd);
        int t, g;
        drive_start(1'b1, f3, a, sd, t);
        g = t + 1 + gd;
        bq.push_back('{nm, ma, 1'b1, strb, wd, 1'b1});
        dq.push_back('{nm, g + 1, last_ld, 1'b0, 1'b0});
        gnt_at(g);
        wait_idle(nm);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        #12;
        chk("rst_req_we_strb", {26'd0, mem_req, mem_we, mem_wstrb}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_flags", {28'd0, busy, done, misaligned, bus_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_load("lw", 3'b010, 32'h100, 0, 2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h100);
        do_load("lb", 3'b000, 32'h103, 0, 1, 32'h8011_2233, 32'hFFFF_FF80, 32'h100);
        do_load("lbu", 3'b100, 32'h103, 1, 1, 32'h8011_2233, 32'h0000_0080, 32'h100);
        do_store("sb", 3'b000, 32'h202, 32'h0000_00A5, 1, 32'h200, 4'b0100, 32'hA5A5_A5A5);
        do_store("sh", 3'b001, 32'h206, 32'h1234_BEEF, 0, 32'h204, 4'b1100, 32'hBEEF_BEEF);
        do_store("sw", 3'b010, 32'h300, 32'hCAFE_F00D, 2, 32'h300, 4'b1111, 32'hCAFE_F00D);
        do_load("lh", 3'b001, 32'h102, 0, 1, 32'h8001_7FFF, 32'hFFFF_8001, 32'h100);
        do_load("lhu", 3'b101, 32'h102, 0, 3, 32'h8001_7FFF, 32'h0000_8001, 32'h100);
`ifdef LSU_MISALIGN_TRAP_EN
        drive_start(1'b0, 3'b001, 32'h101, 32'h0, t);
        dq.push_back('{"lh_trap", t + 1, last_ld, 1'b1, 1'b0});
        wait_idle("lh_trap");
`else
        do_load("lh_mis", 3'b001, 32'h101, 0, 1, 32'h1234_8765, 32'hFFFF_8765, 32'h100);
`endif

        // load never answered: four WAIT cycles then bus error
        drive_start(1'b0, 3'b010, 32'h400, 32'h0, t);
        bq.push_back('{"tmo", 32'h400, 1'b0, 4'b0000, 32'h0, 1'b0});
        dq.push_back('{"tmo", t + 6, last_ld, 1'b0, 1'b1});
        gnt_at(t + 1);
        wait_idle("tmo");

        // second start while in REQ must not disturb the latched load
        drive_start(1'b0, 3'b010, 32'h500, 32'h0, t);
        bq.push_back('{"busy_start", 32'h500, 1'b0, 4'b0000, 32'h0, 1'b0});
        dq.push_back('{"busy_start", t + 5, 32'h1122_3344, 1'b0, 1'b0});
        last_ld = 32'h1122_3344;
        start = 1'b1; is_store = 1'b1; alu_result = 32'h600; store_data = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        start = 1'b0;
        gnt_at(t + 3);
        rv_at(t + 4, 32'h1122_3344);
        wait_idle("busy_start");

        // reset pulse in WAIT, then a stale rvalid
        drive_start(1'b0, 3'b010, 32'h700, 32'h0, t);
        bq.push_back('{"rst_mid", 32'h700, 1'b0, 4'b0000, 32'h0, 1'b0});
        gnt_at(t + 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_req_we_strb", {26'd0, mem_req, mem_we, mem_wstrb}, 32'd0);
        chk("rst_mid_load_data", load_data, 32'd0);
        chk("rst_mid_addr", mem_addr, 32'd0);
        chk("rst_mid_flags", {28'd0, busy, done, misaligned, bus_err}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_ld = 32'd0;
        mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        mem_rvalid = 1'b0; mem_gnt = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("late_rvalid_ld", load_data, 32'd0);
        chk("late_rvalid_busy", {31'd0, busy}, 32'd0);

        do_load("lbu_after_rst", 3'b100, 32'h3, 0, 1, 32'hAB00_0000, 32'h0000_00AB, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("done_queue_empty", dq.size(), 32'd0);
        chk("bus_queue_empty", bq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
